uart_header_rx: RTL and testbench
=================================

// Module: uart_header_rx
// PURPOSE
//  Serial front end feeding the blake2b seed stage. Receives 8N1 UART bytes on uart_rxd,
//  assembles 60 bytes into the 480-bit Equihash header (first byte -> MSBs), and presents
//  it on uart_rdata with a one-cycle uart_done pulse, which blake2b latches as its input block.
// PARAMETERS
//  CLKS_PER_BIT  868         eclk cycles per UART bit (100 MHz / 115200); must be >= 4
//  TIMEOUT_CLKS  10000000    idle eclk cycles before a partial header is discarded (macro only)
// PORTS
//  eclk        in   1    clock
//  rstb        in   1    reset, synchronous, active-low
//  uart_rxd    in   1    asynchronous serial input, idle high
//  uart_done   out  1    one-cycle pulse: uart_rdata holds a complete new header
//  uart_rdata  out  480  assembled header; byte 0 in [479:472], byte 59 in [7:0]
//  rx_busy     out  1    high while a frame is being received (START/DATA/STOP)
//  frame_err   out  1    one-cycle pulse: stop bit sampled low, byte dropped
//  hdr_abort   out  1    one-cycle pulse: partial header discarded on timeout
// BEHAVIOUR
//  - Reset: uart_done=0, uart_rdata=0, rx_busy=0, frame_err=0, hdr_abort=0; FSM IDLE,
//    byte count 0, shift register 0, synchronizer flops reset to 1.
//  - uart_rxd passes a 2-flop synchronizer; all decisions use synchronized rxd_s.
//  - FSM IDLE/START/DATA/STOP, bit timer counts 0..CLKS_PER_BIT-1:
//    IDLE : rxd_s==0 -> START, timer=0.
//    START: at timer==CLKS_PER_BIT/2-1 sample; 0 -> DATA (timer=0, bit=0); 1 -> IDLE (glitch,
//           no error pulse).
//    DATA : at timer==CLKS_PER_BIT-1 sample into byte[bit] (LSB first); after bit 7 -> STOP.
//    STOP : at timer==CLKS_PER_BIT-1 sample; 1 -> byte valid; 0 -> frame_err pulse, byte
//           discarded, count unchanged. Either way -> IDLE on the same edge (no wait for
//           full stop bit; back-to-back frames supported).
//  - rx_busy = (state != IDLE), registered with state.
//  - Byte valid: shift <= {shift[471:0], byte}; count+1. When byte valid and count==59:
//    uart_rdata <= {shift[471:0], byte}, count <= 0, uart_done=1 on the following cycle
//    (1 cycle after the stop-bit sample edge); shift cleared.
//  - uart_rdata holds its value until the next complete header; never updated partially.
//  - uart_done and frame_err never assert in the same cycle; no back-pressure exists,
//    downstream must latch within the 60-byte window before the next header.
//  - Count width 6 bits; values >59 unreachable; any illegal FSM encoding -> IDLE.
//  - rstb low mid-frame or mid-header: everything returns to reset values next edge,
//    partial header lost, uart_rdata cleared.
// CONFIGURATION
//  - UART_HDR_TIMEOUT_EN defined: idle counter runs while state==IDLE and count!=0, cleared
//    on every valid byte or when count==0; reaching TIMEOUT_CLKS-1 -> count=0, shift=0,
//    hdr_abort one-cycle pulse; uart_rdata untouched. A falling start edge in the same
//    cycle wins: counter clears, no abort.
//  - Not defined: no timeout logic; partial header retained indefinitely; hdr_abort tied 0.
// TESTING (bench: CLKS_PER_BIT=16, TIMEOUT_CLKS=2000)
//  - Send bytes 0x00..0x3B -> one uart_done pulse; uart_rdata = 0x000102...3A3B;
//    uart_done 1 cycle after last stop sample; frame_err never pulses.
//  - Byte 5 sent with stop bit 0, then 60 good bytes 0xA5 -> frame_err once, uart_done
//    after the 60th good byte (not before), uart_rdata = all 0xA5 repeated 60 times.
//  - 4-cycle low glitch on idle line -> stays IDLE, no frame_err, count unchanged.
//  - Two headers (0x11 x60 then 0x22 x60) back-to-back, no idle gap -> two uart_done
//    pulses; uart_rdata 0x11.. then 0x22..; rx_busy low only between frames.
//  - rstb low after 30 bytes, then 60 bytes of 0x5A -> uart_rdata=0 until one uart_done,
//    then uart_rdata = 0x5A.. (no residue from first 30 bytes).
//  - UART_HDR_TIMEOUT_EN: 10 bytes, 2500-cycle gap, 60 bytes 0xC3 -> one hdr_abort during
//    gap, single uart_done, uart_rdata = 0xC3 x60; without macro: uart_done after 50th
//    0xC3 byte with first 10 bytes in MSBs.

Source files
------------

// File: rtl/uart_header_rx.sv
// rtl/uart_header_rx.sv - 8N1 UART receiver assembling 60 bytes into a 480-bit header
// Optional idle timeout on partial headers: define UART_HDR_TIMEOUT_EN.
module uart_header_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 10000000
) (
  input  logic         eclk,
  input  logic         rstb,
  input  logic         uart_rxd,
  output logic         uart_done,
  output logic [479:0] uart_rdata,
  output logic         rx_busy,
  output logic         frame_err,
  output logic         hdr_abort
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 4");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic           rxd_meta_q, rxd_s_q;
  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     byte_q, byte_d;
  logic [471:0]   shift_q, shift_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [479:0]   rdata_q, rdata_d;
  logic           done_q, done_d;
  logic           ferr_q, ferr_d;
  logic           busy_q;
  logic           byte_ok;

`ifdef UART_HDR_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CLKS);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CLKS - 1);
  logic [TOW-1:0] idle_q, idle_d;
  logic           abort_q, abort_d;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    byte_ok = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          bit_d   = 3'd0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == T_LAST) begin
          timer_d        = '0;
          byte_d[bit_q]  = rxd_s_q;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
        if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
          if (rxd_s_q) byte_ok = 1'b1;
          else         ferr_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    if (byte_ok) begin
      if (cnt_q == 6'd59) begin
        rdata_d = {shift_q, byte_q};
        shift_d = '0;
        cnt_d   = 6'd0;
        done_d  = 1'b1;
      end else begin
        shift_d = {shift_q[463:0], byte_q};
        cnt_d   = cnt_q + 1'b1;
      end
    end

`ifdef UART_HDR_TIMEOUT_EN
    idle_d  = idle_q;
    abort_d = 1'b0;
    if (state_q != S_IDLE || cnt_q == 6'd0) begin
      idle_d = '0;
    end else if (!rxd_s_q) begin
      idle_d = '0;
    end else if (idle_q == TO_LAST) begin
      idle_d  = '0;
      cnt_d   = 6'd0;
      shift_d = '0;
      abort_d = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge eclk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      shift_q <= '0;
      cnt_q   <= 6'd0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

`ifdef UART_HDR_TIMEOUT_EN
  always_ff @(posedge eclk) begin
    if (!rstb) begin
      idle_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      abort_q <= abort_d;
    end
  end
  assign hdr_abort = abort_q;
`else
  assign hdr_abort = 1'b0;
`endif

  assign uart_done  = done_q;
  assign uart_rdata = rdata_q;
  assign rx_busy    = busy_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_header_rx.sv
// tb/tb_uart_header_rx.sv - directed bench for uart_header_rx (CLKS_PER_BIT=16, TIMEOUT_CLKS=2000)
module tb_uart_header_rx;

  logic         eclk = 1'b0;
  logic         rstb = 1'b0;
  logic         uart_rxd = 1'b1;
  logic         uart_done;
  logic [479:0] uart_rdata;
  logic         rx_busy;
  logic         frame_err;
  logic         hdr_abort;

  always #5 eclk = ~eclk;

  uart_header_rx #(.CLKS_PER_BIT(16), .TIMEOUT_CLKS(2000)) dut (
    .eclk       (eclk),
    .rstb       (rstb),
    .uart_rxd   (uart_rxd),
    .uart_done  (uart_done),
    .uart_rdata (uart_rdata),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .hdr_abort  (hdr_abort)
  );

  int cyc = 0;
  always @(posedge eclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0, ferr_cnt = 0, abort_cnt = 0, both_cnt = 0;
  int last_done_cyc = 0;
  int last_start = 0;
  logic [479:0] rd_log[$];
  logic track = 1'b0;
  int run = 0, run_max = 0, n_runs = 0;

  always @(negedge eclk) begin
    if (uart_done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
      rd_log.push_back(uart_rdata);
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (hdr_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    if (uart_done === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if (rx_busy === 1'b0) begin
      run <= run + 1;
    end else begin
      if (track && run > 0) begin
        n_runs  <= n_runs + 1;
        run_max <= (run > run_max) ? run : run_max;
      end
      run <= 0;
    end
    if (!track) begin
      n_runs  <= 0;
      run_max <= 0;
    end
  end

  task automatic check(input string tag, input logic [479:0] got, input logic [479:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (16) @(posedge eclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge eclk);
    #1;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b, 1'b1);
  endtask

  initial begin
    logic [479:0] hdr_seq;
    hdr_seq = 480'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F202122232425262728292A2B2C2D2E2F303132333435363738393A3B;

    repeat (3) @(posedge eclk);
    @(negedge eclk);
    check("rst_done",  480'(uart_done), 480'd0);
    check("rst_rdata", uart_rdata, 480'd0);
    check("rst_busy",  480'(rx_busy), 480'd0);
    check("rst_ferr",  480'(frame_err), 480'd0);
    check("rst_abort", 480'(hdr_abort), 480'd0);
    @(posedge eclk); #1;
    rstb = 1'b1;
    idle(20);

    // Sequential bytes 0x00..0x3B
    for (int i = 0; i < 59; i++) send_byte(8'(i), 1'b1);
    check("seq_no_early_done", 480'(done_cnt), 480'd0);
    send_byte(8'h3B, 1'b1);
    idle(20);
    check("seq_done_cnt", 480'(done_cnt), 480'd1);
    check("seq_done_latency", 480'(last_done_cyc - last_start), 480'd155);
    check("seq_rdata", uart_rdata, hdr_seq);
    check("seq_no_ferr", 480'(ferr_cnt), 480'd0);
    check("seq_busy_idle", 480'(rx_busy), 480'd0);

    // Framing error then 60 good bytes
    send_byte(8'h05, 1'b0);
    idle(40);
    check("ferr_once", 480'(ferr_cnt), 480'd1);
    send_n(8'hA5, 59);
    check("ferr_no_early_done", 480'(done_cnt), 480'd1);
    send_byte(8'hA5, 1'b1);
    idle(20);
    check("ferr_done_cnt", 480'(done_cnt), 480'd2);
    check("ferr_rdata", uart_rdata, {60{8'hA5}});

    // Short low glitch mid-header must not disturb the byte count
    send_n(8'h33, 20);
    uart_rxd = 1'b0;
    repeat (4) @(posedge eclk);
    #1;
    idle(40);
    check("glitch_no_ferr", 480'(ferr_cnt), 480'd1);
    check("glitch_idle", 480'(rx_busy), 480'd0);
    send_n(8'h44, 39);
    check("glitch_no_early_done", 480'(done_cnt), 480'd2);
    send_byte(8'h44, 1'b1);
    idle(20);
    check("glitch_done_cnt", 480'(done_cnt), 480'd3);
    check("glitch_rdata", uart_rdata, {{20{8'h33}}, {40{8'h44}}});

    // Two headers back-to-back, no idle gap between frames
    send_byte(8'h11, 1'b1);
    track = 1'b1;
    send_n(8'h11, 59);
    send_n(8'h22, 60);
    check("b2b_gap_len", 480'(run_max), 480'd8);
    check("b2b_gap_cnt", 480'(n_runs), 480'd119);
    track = 1'b0;
    idle(20);
    check("b2b_done_cnt", 480'(done_cnt), 480'd5);
    check("b2b_rdata0", (rd_log.size() > 3) ? rd_log[3] : 480'd0, {60{8'h11}});
    check("b2b_rdata1", (rd_log.size() > 4) ? rd_log[4] : 480'd0, {60{8'h22}});

    // Reset mid-header clears everything
    send_n(8'h99, 30);
    rstb = 1'b0;
    repeat (2) @(posedge eclk);
    #1;
    check("rst2_rdata", uart_rdata, 480'd0);
    check("rst2_busy", 480'(rx_busy), 480'd0);
    rstb = 1'b1;
    idle(20);
    send_n(8'h5A, 59);
    check("rst2_rdata_held", uart_rdata, 480'd0);
    check("rst2_no_early_done", 480'(done_cnt), 480'd5);
    send_byte(8'h5A, 1'b1);
    idle(20);
    check("rst2_done_cnt", 480'(done_cnt), 480'd6);
    check("rst2_rdata", uart_rdata, {60{8'h5A}});

    // Partial header followed by a long idle gap
    send_n(8'h77, 10);
    idle(2500);
`ifdef UART_HDR_TIMEOUT_EN
    check("to_abort_once", 480'(abort_cnt), 480'd1);
    send_n(8'hC3, 59);
    check("to_no_early_done", 480'(done_cnt), 480'd6);
    send_byte(8'hC3, 1'b1);
    idle(20);
    check("to_done_cnt", 480'(done_cnt), 480'd7);
    check("to_rdata", uart_rdata, {60{8'hC3}});
    check("to_abort_total", 480'(abort_cnt), 480'd1);
`else
    check("noto_no_abort", 480'(abort_cnt), 480'd0);
    send_n(8'hC3, 49);
    check("noto_no_early_done", 480'(done_cnt), 480'd6);
    send_byte(8'hC3, 1'b1);
    idle(20);
    check("noto_done_cnt", 480'(done_cnt), 480'd7);
    check("noto_rdata", uart_rdata, {{10{8'h77}}, {50{8'hC3}}});
    check("noto_abort_total", 480'(abort_cnt), 480'd0);
`endif

    check("done_ferr_overlap", 480'(both_cnt), 480'd0);
    check("ferr_total", 480'(ferr_cnt), 480'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
